// File: rtl/bip_pkg.sv
// Shared opcodes, FSM state encoding and accumulator-select codes for the BIP control unit.
package bip_pkg;

    // 5-bit opcodes, instr[15:11]; anything not listed decodes as NOP
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_e;

    // Accumulator input selector codes
    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

endpackage

// File: rtl/bip_instruction_decoder.sv
// Combinational opcode decode into datapath strobes and selects, gated by the EXEC qualifier.
module bip_instruction_decoder
    import bip_pkg::*;
(
    input  logic [4:0] i_opcode,
    input  logic       i_exec,
    output logic       o_sel_b,
    output logic [1:0] o_sel_a,
    output logic       o_op,
    output logic       o_wr_acc,
    output logic       o_rd_ram,
    output logic       o_wr_ram
);

    // Map opcode to strobes; everything stays 0 outside EXEC and for HLT/NOP
    always_comb begin
        o_sel_b  = 1'b0;
        o_sel_a  = SELA_RAM;
        o_op     = 1'b0;
        o_wr_acc = 1'b0;
        o_rd_ram = 1'b0;
        o_wr_ram = 1'b0;
        if (i_exec) begin
            case (i_opcode)
                OP_STO: begin
                    o_wr_ram = 1'b1;
                end
                OP_LD: begin
                    o_rd_ram = 1'b1;
                    o_wr_acc = 1'b1;
                    o_sel_a  = SELA_RAM;
                end
                OP_LDI: begin
                    o_wr_acc = 1'b1;
                    o_sel_a  = SELA_IMM;
                end
                OP_ADD, OP_SUB: begin
                    o_rd_ram = 1'b1;
                    o_sel_b  = 1'b0;
                    o_op     = (i_opcode == OP_SUB);
                    o_sel_a  = SELA_ALU;
                    o_wr_acc = 1'b1;
                end
                OP_ADDI, OP_SUBI: begin
                    o_sel_b  = 1'b1;
                    o_op     = (i_opcode == OP_SUBI);
                    o_sel_a  = SELA_ALU;
                    o_wr_acc = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: FETCH/EXEC/HALT sequencer, program counter, run-cycle counter
// and operand sign extension around the combinational instruction decoder.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr_in,
    output logic [PC_W-1:0]   pc_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] imm_ext,
    output logic              sel_b,
    output logic [1:0]        sel_a,
    output logic              op,
    output logic              wr_acc,
    output logic              rd_ram,
    output logic              wr_ram,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_count
);

    state_e             r_state;
    state_e             w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_halted;
    logic [4:0]         w_opcode;
    logic               w_exec;

    assign w_opcode  = instr_in[DATA_W-1 -: 5];
    assign w_exec    = (r_state == EXEC);
    assign data_addr = instr_in[ADDR_W-1:0];
    assign imm_ext   = {{(DATA_W-ADDR_W){instr_in[ADDR_W-1]}}, instr_in[ADDR_W-1:0]};

    assign pc_addr     = r_pc;
    assign cycle_count = r_cnt;
    assign halted      = r_halted;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: two-cycle instruction, HLT parks the machine until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:   w_state_next = EXEC;
            EXEC:    w_state_next = (w_opcode == OP_HLT) ? HALT : FETCH;
            HALT:    w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
    end

    // PC advances at the end of EXEC, except on HLT so it keeps pointing at the HLT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (w_exec && (w_opcode != OP_HLT)) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    // Halted flag mirrors the registered HALT state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_state_next == HALT);
        end
    end

    // Run-cycle counter: counts non-HALT cycles and saturates at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((r_state != HALT) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    bip_instruction_decoder u_decoder (
        .i_opcode (w_opcode),
        .i_exec   (w_exec),
        .o_sel_b  (sel_b),
        .o_sel_a  (sel_a),
        .o_op     (op),
        .o_wr_acc (wr_acc),
        .o_rd_ram (rd_ram),
        .o_wr_ram (wr_ram)
    );

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: decode table, program sequences,
// async reset, PC wrap / counter saturation on a narrow instance, random programs.
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr_in = 16'h0;
    logic [10:0] pc_addr;
    logic [10:0] data_addr;
    logic [15:0] imm_ext;
    logic        sel_b;
    logic [1:0]  sel_a;
    logic        op;
    logic        wr_acc;
    logic        rd_ram;
    logic        wr_ram;
    logic        halted;
    logic [15:0] cycle_count;

    // Narrow instance fed a constant NOP to reach PC wrap and counter saturation quickly
    logic [15:0] instr3 = 16'hF800;
    logic [2:0]  pc3;
    logic [10:0] daddr3;
    logic [15:0] imm3;
    logic        sel_b3, op3, wr_acc3, rd_ram3, wr_ram3, halted3;
    logic [1:0]  sel_a3;
    logic [3:0]  cnt3;

    always #5 clk = ~clk;

    bip_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .pc_addr     (pc_addr),
        .data_addr   (data_addr),
        .imm_ext     (imm_ext),
        .sel_b       (sel_b),
        .sel_a       (sel_a),
        .op          (op),
        .wr_acc      (wr_acc),
        .rd_ram      (rd_ram),
        .wr_ram      (wr_ram),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    bip_control_unit #(.PC_W(3), .DATA_W(16), .ADDR_W(11), .CNT_W(4)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr3),
        .pc_addr     (pc3),
        .data_addr   (daddr3),
        .imm_ext     (imm3),
        .sel_b       (sel_b3),
        .sel_a       (sel_a3),
        .op          (op3),
        .wr_acc      (wr_acc3),
        .rd_ram      (rd_ram3),
        .wr_ram      (wr_ram3),
        .halted      (halted3),
        .cycle_count (cnt3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] rom [0:2047];

    // Reference model: program position, executed-cycle count, phase within instruction
    int m_pc;
    int m_cnt;
    bit m_exec;
    bit m_halt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // {sel_b, sel_a[1:0], op, wr_acc, rd_ram, wr_ram} by mnemonic
    function automatic logic [6:0] exp_dec(input logic [4:0] opc, input bit ex);
        if (!ex) return 7'b0;
        case (opc)
            5'd1:    return 7'b0_00_0_0_0_1; // STO
            5'd2:    return 7'b0_00_0_1_1_0; // LD
            5'd3:    return 7'b0_01_0_1_0_0; // LDI
            5'd4:    return 7'b0_10_0_1_1_0; // ADD
            5'd5:    return 7'b1_10_0_1_0_0; // ADDI
            5'd6:    return 7'b0_10_1_1_1_0; // SUB
            5'd7:    return 7'b1_10_1_1_0_0; // SUBI
            default: return 7'b0;            // HLT, NOP
        endcase
    endfunction

    function automatic logic [15:0] sext11(input logic [15:0] ins);
        int v;
        v = int'(ins & 16'h07FF);
        if (v >= 1024) v = v - 2048;
        return 16'(v);
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] ins;
        ins = rom[m_pc];
        chk({tag, " pc"}, 32'(pc_addr), 32'(m_pc));
        chk({tag, " cycles"}, 32'(cycle_count), 32'(m_cnt));
        chk({tag, " halted"}, 32'(halted), 32'(m_halt));
        chk({tag, " strobes"}, 32'({sel_b, sel_a, op, wr_acc, rd_ram, wr_ram}),
            32'(exp_dec(ins[15:11], m_exec && !m_halt)));
        chk({tag, " data_addr"}, 32'(data_addr), 32'(ins & 16'h07FF));
        chk({tag, " imm_ext"}, 32'(imm_ext), 32'(sext11(ins)));
    endtask

    // Advance model one clock, clock the DUT, present the instruction at the model PC
    task automatic step();
        if (!m_halt) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_exec) begin
                if (rom[m_pc][15:11] == 5'd0) m_halt = 1'b1;
                else m_pc = (m_pc + 1) % 2048;
                m_exec = 1'b0;
            end else begin
                m_exec = 1'b1;
            end
        end
        @(posedge clk);
        #1 instr_in = rom[m_pc];
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_pc = 0; m_cnt = 0; m_exec = 1'b0; m_halt = 1'b0;
        instr_in = rom[0];
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        sel_b;
        logic [1:0]  sel_a;
        logic        op;
        logic        wr_acc;
        logic        rd_ram;
        logic        wr_ram;
        logic [15:0] imm;
        logic [10:0] daddr;
        logic [10:0] pc_after;
        logic        halt_after;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{16'h1805, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 11'h005, 11'd1, 1'b0};
        vecs[1]  = '{16'h2FFF, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 11'h7FF, 11'd1, 1'b0};
        vecs[2]  = '{16'h3003, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 11'h003, 11'd1, 1'b0};
        vecs[3]  = '{16'h0807, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 11'h007, 11'd1, 1'b0};
        vecs[4]  = '{16'h1000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 11'h000, 11'd1, 1'b0};
        vecs[5]  = '{16'h2C00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFC00, 11'h400, 11'd1, 1'b0};
        vecs[6]  = '{16'h2123, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0123, 11'h123, 11'd1, 1'b0};
        vecs[7]  = '{16'h3FFF, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 11'h7FF, 11'd1, 1'b0};
        vecs[8]  = '{16'hF800, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 11'h000, 11'd1, 1'b0};
        vecs[9]  = '{16'h4ABC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h02BC, 11'h2BC, 11'd1, 1'b0};
        vecs[10] = '{16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 11'h000, 11'd0, 1'b1};

        for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;

        // Decode table: FETCH quiet, EXEC strobes, PC after EXEC
        for (int i = 0; i < 11; i++) begin
            rom[0] = vecs[i].instr;
            do_reset();
            check_all("tbl fetch");
            chk("tbl fetch quiet", 32'({sel_b, sel_a, op, wr_acc, rd_ram, wr_ram}), 32'd0);
            step();
            check_all("tbl exec");
            chk("tbl exec strobes", 32'({sel_b, sel_a, op, wr_acc, rd_ram, wr_ram}),
                32'({vecs[i].sel_b, vecs[i].sel_a, vecs[i].op, vecs[i].wr_acc,
                     vecs[i].rd_ram, vecs[i].wr_ram}));
            chk("tbl imm_ext", 32'(imm_ext), 32'(vecs[i].imm));
            chk("tbl data_addr", 32'(data_addr), 32'(vecs[i].daddr));
            step();
            chk("tbl pc after", 32'(pc_addr), 32'(vecs[i].pc_after));
            chk("tbl halted after", 32'(halted), 32'(vecs[i].halt_after));
        end

        // Short program ending in HLT, then 20 idle cycles in HALT
        for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
        rom[0] = 16'h1805; rom[1] = 16'h2FFF; rom[2] = 16'h3003; rom[3] = 16'h0807;
        rom[4] = 16'h0000;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            check_all("prog");
        end
        chk("prog halted", 32'(halted), 32'd1);
        chk("prog pc", 32'(pc_addr), 32'd4);
        chk("prog cycles", 32'(cycle_count), 32'd10);
        for (int i = 0; i < 20; i++) begin
            step();
            check_all("halt hold");
            chk("halt quiet", 32'({sel_b, sel_a, op, wr_acc, rd_ram, wr_ram}), 32'd0);
        end
        chk("halt cycles held", 32'(cycle_count), 32'd10);

        // Asynchronous reset in the middle of a STO execute cycle
        for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
        rom[2] = 16'h0807;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check_all("pre-areset");
        chk("sto wr_ram", 32'(wr_ram), 32'd1);
        reset = 1'b1;
        #1;
        chk("areset wr_ram", 32'(wr_ram), 32'd0);
        chk("areset pc", 32'(pc_addr), 32'd0);
        chk("areset cycles", 32'(cycle_count), 32'd0);
        chk("areset halted", 32'(halted), 32'd0);
        m_pc = 0; m_cnt = 0; m_exec = 1'b0; m_halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        instr_in = rom[0];
        #1;
        check_all("post-areset");
        step();
        check_all("post-areset exec");

        // Narrow instance: PC 7 -> 0 wrap and 4-bit counter saturation
        do_reset();
        for (int i = 0; i < 14; i++) step();
        chk("w3 pc 7", 32'(pc3), 32'd7);
        chk("w3 cnt 14", 32'(cnt3), 32'd14);
        step(); step();
        chk("w3 pc wrap", 32'(pc3), 32'd0);
        chk("w3 cnt 15", 32'(cnt3), 32'd15);
        step(); step();
        chk("w3 pc 1", 32'(pc3), 32'd1);
        chk("w3 cnt sat", 32'(cnt3), 32'd15);
        chk("w3 nop quiet", 32'({sel_b3, sel_a3, op3, wr_acc3, rd_ram3, wr_ram3}), 32'd0);

        // Random programs against the model; HLT kept rare so programs mostly run on
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2048; i++) begin
                logic [4:0] opc;
                opc = 5'($urandom_range(0, 31));
                if (opc == 5'd0 && $urandom_range(0, 15) != 0) opc = 5'd7;
                if ($urandom_range(0, 3) == 0) opc = 5'($urandom_range(1, 7));
                rom[i] = {opc, 11'($urandom_range(0, 2047))};
            end
            do_reset();
            check_all("rnd reset");
            for (int i = 0; i < 300; i++) begin
                step();
                check_all("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Sequencing and decode stage of the accumulator processor datapath.
- Drives the program-memory address and decodes the fetched 16-bit instruction.
- Generates select lines for the 16-bit 2-to-1 operand multiplexer (RAM data vs. immediate into the ALU B input) and for the 3-way accumulator-input selector.
- Also generates the accumulator, RAM and ALU strobes, and a run-cycle counter read by the debug unit.

Parameters:
PC_W, 11, program counter / program-memory address width
DATA_W, 16, datapath and instruction width
ADDR_W, 11, data-memory address width (instruction operand field width)
CNT_W, 16, cycle counter width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
instr_in  in  DATA_W  instruction from program memory, valid one cycle after pc_addr (synchronous ROM)
pc_addr  out  PC_W  program-memory address (registered PC)
data_addr  out  ADDR_W  data-memory address = instr_in[ADDR_W-1:0]
imm_ext  out  DATA_W  operand field sign-extended to DATA_W; feeds DatoB of the operand mux
sel_b  out  1  operand mux select: 0 = RAM data, 1 = imm_ext
sel_a  out  2  accumulator input select: 00 RAM, 01 imm_ext, 10 ALU result
op  out  1  ALU operation: 0 add, 1 subtract
wr_acc  out  1  accumulator write enable
rd_ram  out  1  data-memory read strobe
wr_ram  out  1  data-memory write strobe (store accumulator)
halted  out  1  high while in HALT
cycle_count  out  CNT_W  cycles executed since reset

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Instruction format: opcode = instr_in[15:11], operand = instr_in[10:0].
- Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI. All other opcodes are NOP.
- FSM states: FETCH, EXEC, HALT.
  - Reset → FETCH.
  - FETCH → EXEC unconditionally.
  - EXEC → HALT if opcode = HLT, else → FETCH.
  - HALT holds until reset.
- Each instruction takes 2 cycles (FETCH, EXEC).
- PC:
  - Reset value 0; drives pc_addr directly.
  - Increments at the end of EXEC for every opcode except HLT.
  - Wraps from 2^PC_W-1 to 0.
  - In HALT the PC holds its value, i.e. the address of the HLT instruction.
- Decode outputs are combinational from instr_in, qualified by state == EXEC.
  - Outside EXEC: all strobes, sel_a, sel_b and op are 0.
  - Downstream registers capture on the clock edge that ends EXEC.
- Strobe settings per opcode during EXEC:
  - STO: wr_ram.
  - LD: rd_ram, wr_acc, sel_a = 00.
  - LDI: wr_acc, sel_a = 01.
  - ADD: rd_ram, sel_b = 0, op = 0, sel_a = 10, wr_acc.
  - ADDI: sel_b = 1, op = 0, sel_a = 10, wr_acc.
  - SUB: as ADD with op = 1.
  - SUBI: as ADDI with op = 1.
  - HLT and NOP: no strobes.
- data_addr and imm_ext are always driven from instr_in, ungated.
- imm_ext = {(DATA_W-ADDR_W) copies of instr_in[10], instr_in[10:0]}.
- halted: registered, 1 exactly when state == HALT.
- cycle_count:
  - Reset value 0.
  - Increments on every edge where state != HALT.
  - Saturates at all-ones; never wraps.
- Reset values: pc_addr 0, cycle_count 0, halted 0. All combinational outputs settle to 0 because state = FETCH.
- Reset mid-operation: takes effect immediately and asynchronously. An in-flight EXEC strobe (e.g. wr_ram) deasserts without waiting for a clock edge.
- There are no simultaneous-event conflicts: a single instruction source, and no stall input.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams OP_HLT through OP_SUBI;
  - state encoding (FETCH, EXEC, HALT);
  - sel_a encodings (SELA_RAM, SELA_IMM, SELA_ALU).
- Sub-module bip_instruction_decoder: purely combinational map from opcode plus exec qualifier to strobes and selects.
- The top level keeps the FSM, PC, counter and sign extension.

Test Plan:
1. Reset released, instr_in = 0x1805 (LDI 5) at pc 0 → cycle 1 FETCH with pc_addr = 0; cycle 2 EXEC with sel_a = 01, imm_ext = 0x0005, wr_acc = 1; pc_addr = 1 after the edge.
2. ADDI -1 (0x2FFF) → imm_ext = 0xFFFF, sel_b = 1, op = 0, sel_a = 10, wr_acc = 1, rd_ram = 0 during EXEC only.
3. SUB 3 (0x3003) → data_addr = 0x003, rd_ram = 1, sel_b = 0, op = 1, sel_a = 10, wr_acc = 1; STO 7 (0x0807) → wr_ram = 1 only.
4. Program LDI, ADDI, SUB, STO, HLT at pc 0–4 → halted = 1 after the 10th edge; pc_addr holds 4; cycle_count holds 10; all strobes stay 0 for 20 further cycles.
5. Opcode 11111 (0xF800) → no strobes asserted, pc advances by 1. With PC_W = 3, NOP sequence → pc_addr goes 7 → 0.
6. Assert reset asynchronously mid-EXEC of STO → wr_ram drops before the next clk edge; pc_addr = 0, cycle_count = 0, FETCH on release.
